fifo_flagged: RTL
=================

// Module: fifo_flagged
// PURPOSE
//   Single-clock, first-word-fall-through FIFO replacing the plain fifo wherever producers/consumers
//   need occupancy, watermarks or protection. Adds level output, programmable almost-full/empty
//   watermarks, synchronous flush, and guarded push/pop (illegal ops ignored). Sits between
//   pipeline stages and bus/peripheral queues.
// PARAMETERS
//   data_width          32   bits per entry
//   depth_bits          4    log2 of depth; depth = 1 << depth_bits (>= 1)
//   almost_full_level   14   almost_full asserts when level >= this (0..depth)
//   almost_empty_level  2    almost_empty asserts when level <= this (0..depth)
// PORTS
//   clk            in   1               clock, all state on rising edge
//   reset          in   1               asynchronous, active-high reset
//   clear          in   1               synchronous flush
//   write_data     in   data_width      push data
//   write_enable   in   1               push request
//   read_enable    in   1               pop request
//   read_data      out  data_width      head entry (FWFT)
//   empty          out  1               level == 0
//   full           out  1               level == depth
//   almost_empty   out  1               level <= almost_empty_level
//   almost_full    out  1               level >= almost_full_level
//   level          out  depth_bits+1    current occupancy 0..depth
//   overflow       out  1               sticky, only with FIFO_ERR_FLAGS_EN
//   underflow      out  1               sticky, only with FIFO_ERR_FLAGS_EN
// BEHAVIOUR
//   - Reset (async assert, sync to clk on release): write_addr=read_addr=0, level=0 -> empty=1,
//     full=0, almost_empty=1, almost_full=(almost_full_level==0); overflow=underflow=0.
//     Storage not reset; read_data undefined while empty.
//   - read_accept  = read_enable & !empty.
//   - write_accept = write_enable & (!full | read_enable). Push while full is accepted only if the
//     same cycle pops (level stays depth).
//   - Empty + push + pop: pop rejected, push accepted, level 0->1; no write-through bypass.
//   - Accepted push: mem[write_addr] <= write_data, write_addr +1 mod depth.
//   - Accepted pop: read_addr +1 mod depth. read_data = mem[read_addr], combinational; the new head
//     is visible the cycle after the pop. A pushed word is visible the cycle after the push.
//   - level_next = level + write_accept - read_accept. All flags derive combinationally from
//     registered level. No flag has latency beyond the updating edge.
//   - Pointers wrap silently; full/empty come from level only, never from pointer compare.
//   - clear=1: pointers and level -> 0 on the edge. Overrides push/pop in the same cycle; the pushed
//     word is discarded. Sticky error flags are also cleared.
//   - Reset mid-operation discards all contents; no partial state survives.
// CONFIGURATION
//   FIFO_ERR_FLAGS_EN defined:
//     - overflow sets on write_enable & !write_accept.
//     - underflow sets on read_enable & empty.
//     - Both are sticky until reset or clear. clear in the same cycle wins, so the flag is not set.
//   FIFO_ERR_FLAGS_EN undefined:
//     - overflow/underflow ports absent; illegal ops are still ignored silently.
// TESTING (depth_bits=2, depth=4, almost_full_level=3, almost_empty_level=1)
//   1 Reset, push A,B,C,D -> level 1,2,3,4; almost_full at level 3; full at 4; read_data=A
//     throughout.
//   2 Full: push E alone -> ignored, level 4, overflow=1 (macro on). Push E + pop -> read_data B
//     next cycle, level 4, E read fifth.
//   3 Empty: pop -> level 0, underflow=1. Push X + pop same cycle -> level 1, read_data=X next cycle.
//   4 Wrap: 10 cycles of simultaneous push/pop of 0..9 at level 2 -> pops return 0..9 in order,
//     level stays 2, flags steady.
//   5 Fill to 3, assert clear with push -> level 0, empty=1, overflow=underflow=0, pushed word lost.
//   6 Assert reset asynchronously mid-stream, between edges -> outputs take reset values before the
//     next edge.

Source files
------------

// File: rtl/fifo_flagged.sv
// Single-clock first-word-fall-through FIFO with occupancy level, watermarks and flush.
// Define FIFO_ERR_FLAGS_EN to add the sticky overflow/underflow outputs.
module fifo_flagged #(
  parameter int data_width         = 32,
  parameter int depth_bits         = 4,
  parameter int almost_full_level  = 14,
  parameter int almost_empty_level = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [data_width-1:0] write_data,
  input  logic                  write_enable,
  input  logic                  read_enable,
  output logic [data_width-1:0] read_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [depth_bits:0]   level
);

  localparam int depth = 1 << depth_bits;
  localparam logic [depth_bits:0] depth_lvl = (depth_bits + 1)'(depth);
  localparam logic [depth_bits:0] af_lvl    = (depth_bits + 1)'(almost_full_level);
  localparam logic [depth_bits:0] ae_lvl    = (depth_bits + 1)'(almost_empty_level);
  localparam logic [depth_bits:0] lvl_one   = 1;
  localparam logic [depth_bits-1:0] addr_one = 1;

  logic [data_width-1:0] mem [depth];
  logic [depth_bits-1:0] write_addr;
  logic [depth_bits-1:0] read_addr;
  logic [depth_bits:0]   level_q;
  logic                  read_accept;
  logic                  write_accept;

  assign empty        = (level_q == '0);
  assign full         = (level_q == depth_lvl);
  assign almost_empty = (level_q <= ae_lvl);
  assign almost_full  = (level_q >= af_lvl);
  assign level        = level_q;

  // A push into a full FIFO is legal only when the same cycle frees a slot.
  assign read_accept  = read_enable & ~empty;
  assign write_accept = write_enable & (~full | read_enable);

  assign read_data = mem[read_addr];

  always_ff @(posedge clk) begin
    if (write_accept && !clear) begin
      mem[write_addr] <= write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_addr <= '0;
      read_addr  <= '0;
      level_q    <= '0;
    end else if (clear) begin
      write_addr <= '0;
      read_addr  <= '0;
      level_q    <= '0;
    end else begin
      if (write_accept) write_addr <= write_addr + addr_one;
      if (read_accept)  read_addr  <= read_addr + addr_one;
      case ({write_accept, read_accept})
        2'b10:   level_q <= level_q + lvl_one;
        2'b01:   level_q <= level_q - lvl_one;
        default: level_q <= level_q;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky until reset or flush; a flush in the same cycle suppresses the set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_enable && !write_accept) overflow  <= 1'b1;
      if (read_enable && empty)          underflow <= 1'b1;
    end
  end
`endif

endmodule
